// File: rtl/mem_stage_if.sv
// Bundle and data-bus signals between EX, MEM, WB and ID.
// slave is the MEM stage view; master is the surrounding pipeline view.
interface mem_stage_if;
    logic         ex_to_mem_valid;
    logic [105:0] ex_to_mem_data;
    logic         mem_allow;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_allow;
    logic         mem_to_wb_valid;
    logic [101:0] mem_to_wb_data;
    logic [5:0]   mem_wr;
    logic [37:0]  mem_to_id_fwd;

    modport master (
        output ex_to_mem_valid, ex_to_mem_data,
        output data_sram_data_ok, data_sram_rdata,
        output wb_allow,
        input  mem_allow, mem_to_wb_valid, mem_to_wb_data,
        input  mem_wr, mem_to_id_fwd
    );

    modport slave (
        input  ex_to_mem_valid, ex_to_mem_data,
        input  data_sram_data_ok, data_sram_rdata,
        input  wb_allow,
        output mem_allow, mem_to_wb_valid, mem_to_wb_data,
        output mem_wr, mem_to_id_fwd
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: waits for load data, aligns/extends it, feeds WB.
// Define MEM_FWD_EN to drive mem_to_id_fwd; otherwise it is tied to 0.
module mem_stage (
    input logic      clk,
    input logic      resetn,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_HOLD,
        S_READY
    } state_t;

    state_t state;
    state_t state_nx;

    logic [105:0] bundle;
    logic [31:0]  buf_rdata;
    logic         capture;

    logic         res_from_mem;
    logic [2:0]   ld_op;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  alu_result;
    logic [31:0]  pc;
    logic [31:0]  inst;

    assign res_from_mem = bundle[105];
    assign ld_op        = bundle[104:102];
    assign gr_we        = bundle[101];
    assign dest         = bundle[100:96];
    assign alu_result   = bundle[95:64];
    assign pc           = bundle[63:32];
    assign inst         = bundle[31:0];

    logic mem_valid;
    logic buf_valid;
    logic mem_ready;
    logic mem_allow;
    logic accept;

    // The stage is invalid while reset is held, so outputs go quiet at once.
    assign mem_valid = resetn & (state != S_EMPTY);
    assign buf_valid = (state == S_HOLD);
    assign mem_ready = ~res_from_mem | buf_valid | bus.data_sram_data_ok;
    assign mem_allow = ~mem_valid | (mem_ready & bus.wb_allow);
    assign accept    = resetn & mem_allow & bus.ex_to_mem_valid;

    // Next state: a new bundle replaces the old one whenever allowed.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        if (mem_allow) begin
            if (!bus.ex_to_mem_valid)
                state_nx = S_EMPTY;
            else if (bus.ex_to_mem_data[105])
                state_nx = S_WAIT;
            else
                state_nx = S_READY;
        end else if (state == S_WAIT && bus.data_sram_data_ok) begin
            state_nx = S_HOLD;
            capture  = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    // Bundle register loads on every accepted EX bundle.
    always_ff @(posedge clk) begin
        if (accept)
            bundle <= bus.ex_to_mem_data;
    end

    // Hold returned load data while WB is stalled.
    always_ff @(posedge clk) begin
        if (capture)
            buf_rdata <= bus.data_sram_rdata;
    end

    logic [31:0] rdata;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign rdata   = buf_valid ? buf_rdata : bus.data_sram_rdata;
    assign off     = alu_result[1:0];
    assign ld_byte = rdata[{off, 3'b000} +: 8];
    assign ld_half = rdata[{off[1], 4'b0000} +: 16];

    // Align and extend the load word according to ld_op.
    always_comb begin
        load_data = rdata;
        case (ld_op)
            3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  load_data = {24'b0, ld_byte};
            3'b011:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {16'b0, ld_half};
            default: load_data = rdata;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    assign bus.mem_allow       = mem_allow;
    assign bus.mem_to_wb_valid = mem_valid & mem_ready;
    assign bus.mem_to_wb_data  = {gr_we, pc, inst, final_result, dest};
    assign bus.mem_wr          = mem_valid ? {gr_we, dest} : 6'b0;

`ifdef MEM_FWD_EN
    logic fwd_valid;
    assign fwd_valid = mem_valid & gr_we & mem_ready;
    assign bus.mem_to_id_fwd = fwd_valid ? {1'b1, dest, final_result}
                                         : 38'b0;
`else
    assign bus.mem_to_id_fwd = 38'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then random traffic
// checked against a cycle-level reference model of the stage.
module tb_mem_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    mem_stage_if bus();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what instruction sits in MEM and its buffered data.
    logic         m_valid = 1'b0;
    logic         m_got   = 1'b0;
    logic [31:0]  m_buf   = '0;
    logic [105:0] m_b     = '0;
    logic         m_allow = 1'b1;

    logic         d_rn;
    logic         d_ev;
    logic         d_dok;
    logic         d_wa;
    logic [105:0] d_ed;
    logic [31:0]  d_rd;

    function automatic logic [31:0] ext(input logic [2:0] op,
                                        input logic [1:0] off,
                                        input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [105:0] mk(input logic res,
                                        input logic [2:0] op,
                                        input logic we,
                                        input logic [4:0] d,
                                        input logic [31:0] alu);
        logic [31:0] pc;
        logic [31:0] inst;
        pc   = $urandom;
        inst = $urandom;
        return {res, op, we, d, alu, pc, inst};
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic ev,
                         input logic [105:0] ed, input logic dok,
                         input logic [31:0] rd, input logic wa);
        logic v;
        logic rdy;
        logic [31:0] data;
        logic [31:0] res;
        logic wbv;
        logic fv;
        d_rn = rn; d_ev = ev; d_ed = ed;
        d_dok = dok; d_rd = rd; d_wa = wa;
        resetn = rn;
        bus.ex_to_mem_valid   = ev;
        bus.ex_to_mem_data    = ed;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata   = rd;
        bus.wb_allow          = wa;
        #1;
        v   = rn && m_valid;
        rdy = 1'b1;
        res = '0;
        if (v) begin
            rdy  = !m_b[105] || m_got || dok;
            data = m_got ? m_buf : rd;
            res  = m_b[105] ? ext(m_b[104:102], m_b[65:64], data)
                            : m_b[95:64];
        end
        m_allow = !v || (rdy && wa);
        wbv     = v && rdy;
        chk("mem_allow", bus.mem_allow, m_allow);
        chk("wb_valid", bus.mem_to_wb_valid, wbv);
        if (wbv)
            chk("wb_data", bus.mem_to_wb_data,
                {m_b[101], m_b[63:32], m_b[31:0], res, m_b[100:96]});
        chk("mem_wr", bus.mem_wr, v ? {m_b[101], m_b[100:96]} : 6'b0);
`ifdef MEM_FWD_EN
        fv = v && m_b[101] && rdy;
        chk("fwd", bus.mem_to_id_fwd,
            fv ? {1'b1, m_b[100:96], res} : 38'b0);
`else
        fv = 1'b0;
        chk("fwd", bus.mem_to_id_fwd, {fv, 37'b0});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!d_rn) begin
            m_valid = 1'b0;
            m_got   = 1'b0;
        end else if (m_allow) begin
            m_valid = d_ev;
            if (d_ev) begin
                m_b   = d_ed;
                m_got = 1'b0;
            end
        end else if (m_valid && m_b[105] && !m_got && d_dok) begin
            m_got = 1'b1;
            m_buf = d_rd;
        end
        #1;
    endtask

    logic [105:0] nb;

    initial begin
        nb = '0;
        // Reset
        drive(0, 0, nb, 0, 0, 1);
        chk("rst_allow", bus.mem_allow, 1'b1);
        chk("rst_wbv", bus.mem_to_wb_valid, 1'b0);
        tick();
        drive(0, 0, nb, 0, 0, 1);
        tick();

        // Non-load add
        drive(1, 1, mk(0, 3'd0, 1, 5'd5, 32'h1234), 0, 0, 1);
        tick();
        drive(1, 0, nb, 0, 0, 1);
        chk("add_wbv", bus.mem_to_wb_valid, 1'b1);
        chk("add_res", bus.mem_to_wb_data[36:5], 32'h00001234);
        chk("add_wr", bus.mem_wr, 6'b100101);
        tick();

        // lb, data in first cycle
        drive(1, 1, mk(1, 3'd1, 1, 5'd7, 32'h1003), 0, 0, 1);
        tick();
        drive(1, 0, nb, 1, 32'h80AA5500, 1);
        chk("lb_wbv", bus.mem_to_wb_valid, 1'b1);
        chk("lb_res", bus.mem_to_wb_data[36:5], 32'hFFFFFF80);
        tick();

        // lhu, slow response
        drive(1, 1, mk(1, 3'd4, 1, 5'd9, 32'h2002), 0, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, nb, 0, 32'h55555555, 1);
            chk("lhu_wait_wbv", bus.mem_to_wb_valid, 1'b0);
            chk("lhu_wait_allow", bus.mem_allow, 1'b0);
            tick();
        end
        drive(1, 0, nb, 1, 32'hBEEF0000, 1);
        chk("lhu_res", bus.mem_to_wb_data[36:5], 32'h0000BEEF);
        tick();

        // WB stall with buffered data
        drive(1, 1, mk(1, 3'd0, 1, 5'd3, 32'h3000), 0, 0, 1);
        tick();
        drive(1, 0, nb, 1, 32'h12345678, 0);
        tick();
        drive(1, 0, nb, 1, 32'hDEADDEAD, 0);
        chk("hold_wbv", bus.mem_to_wb_valid, 1'b1);
        chk("hold_allow", bus.mem_allow, 1'b0);
        tick();
        drive(1, 0, nb, 0, 32'hA5A5A5A5, 1);
        chk("hold_res", bus.mem_to_wb_data[36:5], 32'h12345678);
        tick();

        // Back-to-back lw, sw, lbu
        drive(1, 1, mk(1, 3'd0, 1, 5'd1, 32'h4000), 0, 0, 1);
        tick();
        drive(1, 1, mk(0, 3'd0, 0, 5'd0, 32'h4444), 1, 32'hCAFEF00D, 1);
        chk("b2b_lw", bus.mem_to_wb_data[36:5], 32'hCAFEF00D);
        chk("b2b_allow", bus.mem_allow, 1'b1);
        tick();
        drive(1, 1, mk(1, 3'd2, 1, 5'd2, 32'h5001), 1, 32'h77777777, 1);
        chk("b2b_sw", bus.mem_to_wb_data[36:5], 32'h00004444);
        tick();
        drive(1, 0, nb, 1, 32'h0000AB00, 1);
        chk("b2b_lbu", bus.mem_to_wb_data[36:5], 32'h000000AB);
        tick();

        // Reset while waiting
        drive(1, 1, mk(1, 3'd0, 1, 5'd4, 32'h6000), 0, 0, 1);
        tick();
        drive(0, 0, nb, 0, 0, 1);
        tick();
        drive(1, 0, nb, 0, 0, 1);
        chk("rst_wait_wbv", bus.mem_to_wb_valid, 1'b0);
        chk("rst_wait_allow", bus.mem_allow, 1'b1);
        tick();

`ifdef MEM_FWD_EN
        drive(1, 1, mk(1, 3'd0, 1, 5'd6, 32'h7000), 0, 0, 1);
        tick();
        drive(1, 0, nb, 0, 0, 1);
        chk("fwd_wait", bus.mem_to_id_fwd[37], 1'b0);
        tick();
        drive(1, 0, nb, 1, 32'h13579BDF, 1);
        chk("fwd_done", bus.mem_to_id_fwd[37], 1'b1);
        tick();
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 3) != 0,
                  mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom),
                     32'($urandom)),
                  $urandom_range(0, 2) == 0,
                  32'($urandom),
                  $urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
